picorv32_pcpi_issuer: RTL and testbench

Initiator side of the PCPI coprocessor interface. It accepts one instruction at a time from the core's execute stage over a valid/ready request channel. It drives `pcpi_valid`/`pcpi_insn`/`pcpi_rs1`/`pcpi_rs2` until a coprocessor such as the fast multiplier answers with `pcpi_ready`, or until a timeout expires. It then returns the write-back result, or an illegal-instruction indication, over a valid/ready response channel.

---
 rtl/picorv32_pcpi_issuer.sv | 143 ++++++++++++++
 tb/tb_picorv32_pcpi_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_pcpi_issuer.sv
// PCPI initiator: issues one instruction at a time to an attached coprocessor and
// returns its write-back result, or an illegal-instruction trap on timeout.
module picorv32_pcpi_issuer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_EXTENDS   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic [4:0]  rsp_rdaddr,
    output logic        rsp_illegal
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pvalid_q, pvalid_d;
    logic [31:0]   pinsn_q, pinsn_d;
    logic [31:0]   prs1_q, prs1_d;
    logic [31:0]   prs2_q, prs2_d;
    logic          rvalid_q, rvalid_d;
    logic          rwr_q, rwr_d;
    logic [31:0]   rrd_q, rrd_d;
    logic [4:0]    raddr_q, raddr_d;
    logic          rill_q, rill_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            pvalid_q <= 1'b0;
            pinsn_q  <= '0;
            prs1_q   <= '0;
            prs2_q   <= '0;
            rvalid_q <= 1'b0;
            rwr_q    <= 1'b0;
            rrd_q    <= '0;
            raddr_q  <= '0;
            rill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pvalid_q <= pvalid_d;
            pinsn_q  <= pinsn_d;
            prs1_q   <= prs1_d;
            prs2_q   <= prs2_d;
            rvalid_q <= rvalid_d;
            rwr_q    <= rwr_d;
            rrd_q    <= rrd_d;
            raddr_q  <= raddr_d;
            rill_q   <= rill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pvalid_d = pvalid_q;
        pinsn_d  = pinsn_q;
        prs1_d   = prs1_q;
        prs2_d   = prs2_q;
        rvalid_d = rvalid_q;
        rwr_d    = rwr_q;
        rrd_d    = rrd_q;
        raddr_d  = raddr_q;
        rill_d   = rill_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pinsn_d  = req_insn;
                    prs1_d   = req_rs1;
                    prs2_d   = req_rs2;
                    pvalid_d = 1'b1;
                    timer_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Ready outranks the timeout so a last-cycle answer never traps.
                if (pcpi_ready) begin
                    rwr_d    = pcpi_wr;
                    rrd_d    = pcpi_wr ? pcpi_rd : '0;
                    rill_d   = 1'b0;
                    raddr_d  = pinsn_q[11:7];
                    rvalid_d = 1'b1;
                    pvalid_d = 1'b0;
                    state_d  = RESP;
                end else if (pcpi_wait && (WAIT_EXTENDS != 0)) begin
                    timer_d = '0;
                end else if (timer_q == TLAST) begin
                    rwr_d    = 1'b0;
                    rrd_d    = '0;
                    rill_d   = 1'b1;
                    raddr_d  = pinsn_q[11:7];
                    rvalid_d = 1'b1;
                    pvalid_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE) && resetn;
    assign pcpi_valid  = pvalid_q;
    assign pcpi_insn   = pinsn_q;
    assign pcpi_rs1    = prs1_q;
    assign pcpi_rs2    = prs2_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_wr      = rwr_q;
    assign rsp_rd      = rrd_q;
    assign rsp_rdaddr  = raddr_q;
    assign rsp_illegal = rill_q;

endmodule

// File: tb/tb_picorv32_pcpi_issuer.sv
// Randomized bench for picorv32_pcpi_issuer: two instances (wait extends / wait ignored)
// share stimulus, only the selected one sees requests; results checked against a timing model.
module tb_picorv32_pcpi_issuer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0;
    logic        pcpi_wr = 1'b0, pcpi_wait = 1'b0, pcpi_ready = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        rsp_ready = 1'b0;

    logic        rq_rdy [2];
    logic        p_val [2];
    logic [31:0] p_insn [2], p_rs1 [2], p_rs2 [2];
    logic        r_val [2], r_wr [2], r_ill [2];
    logic [31:0] r_rd [2];
    logic [4:0]  r_addr [2];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    picorv32_pcpi_issuer #(.TIMEOUT_CYCLES(T), .WAIT_EXTENDS(1)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid && !sel), .req_ready(rq_rdy[0]),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .pcpi_valid(p_val[0]), .pcpi_insn(p_insn[0]), .pcpi_rs1(p_rs1[0]), .pcpi_rs2(p_rs2[0]),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .rsp_valid(r_val[0]), .rsp_ready(rsp_ready), .rsp_wr(r_wr[0]), .rsp_rd(r_rd[0]),
        .rsp_rdaddr(r_addr[0]), .rsp_illegal(r_ill[0])
    );

    picorv32_pcpi_issuer #(.TIMEOUT_CYCLES(T), .WAIT_EXTENDS(0)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid && sel), .req_ready(rq_rdy[1]),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .pcpi_valid(p_val[1]), .pcpi_insn(p_insn[1]), .pcpi_rs1(p_rs1[1]), .pcpi_rs2(p_rs2[1]),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .rsp_valid(r_val[1]), .rsp_ready(rsp_ready), .rsp_wr(r_wr[1]), .rsp_rd(r_rd[1]),
        .rsp_rdaddr(r_addr[1]), .rsp_illegal(r_ill[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in for the fast multiplier: RV32M MUL/MULH/MULHSU/MULHU.
    function automatic logic [31:0] mul_ref(input logic [31:0] insn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (insn[14:12])
            3'd0:    p = sa * sb;
            3'd1:    p = sa * sb;
            3'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (insn[14:12] == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    // r: issue cycle (0-based) on which the responder raises ready, -1 = never.
    // w: number of leading issue cycles with pcpi_wait high. bp: rsp_ready-low cycles.
    task automatic run_txn(input logic s, input logic [31:0] insn, input logic [31:0] rs1,
                           input logic [31:0] rs2, input int r, input int w, input logic wr,
                           input logic [31:0] rd, input int bp, output logic [31:0] got_rd);
        int  cnt, dl, exp_cnt;
        logic exp_ill, exp_wr;
        logic [31:0] exp_rd;

        sel = s;
        cnt = 0;
        pcpi_ready = 1'($urandom);
        @(negedge clk);
        while (!rq_rdy[s] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("req_ready_idle", rq_rdy[s], 1);
        check_eq("no_rsp_idle", r_val[s], 0);
        req_valid = 1'b1;
        req_insn = insn;
        req_rs1 = rs1;
        req_rs2 = rs2;
        pcpi_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_insn = $urandom;
        req_rs1 = $urandom;
        req_rs2 = $urandom;

        cnt = 0;
        forever begin
            pcpi_wait  = (cnt < w);
            pcpi_ready = (cnt == r);
            pcpi_wr    = (cnt == r) ? wr : 1'($urandom);
            pcpi_rd    = (cnt == r) ? rd : $urandom;
            @(negedge clk);
            check_eq("pcpi_valid_hi", p_val[s], 1);
            check_eq("pcpi_insn_hold", p_insn[s], insn);
            check_eq("pcpi_ops_hold", {p_rs1[s], p_rs2[s]}, {rs1, rs2});
            cnt++;
            @(posedge clk);
            #1;
            if (!p_val[s] || cnt >= 200) break;
        end
        pcpi_wait = 1'b0;
        pcpi_wr = 1'($urandom);
        pcpi_rd = $urandom;

        dl = ((s == 1'b0) ? w : 0) + T - 1;
        if (r >= 0 && r <= dl) begin
            exp_cnt = r + 1;
            exp_ill = 1'b0;
            exp_wr  = wr;
            exp_rd  = wr ? rd : 32'd0;
        end else begin
            exp_cnt = dl + 1;
            exp_ill = 1'b1;
            exp_wr  = 1'b0;
            exp_rd  = 32'd0;
        end
        check_eq("pcpi_valid_cycles", cnt, exp_cnt);

        got_rd = r_rd[s];
        req_valid = 1'b1;
        for (int i = 0; i <= bp; i++) begin
            pcpi_ready = 1'($urandom);
            @(negedge clk);
            check_eq("rsp_valid", r_val[s], 1);
            check_eq("rsp_fields", {r_wr[s], r_ill[s], r_addr[s], r_rd[s]},
                     {exp_wr, exp_ill, insn[11:7], exp_rd});
            check_eq("req_ready_resp", rq_rdy[s], 0);
            check_eq("pcpi_valid_lo", p_val[s], 0);
            if (i == 0) got_rd = r_rd[s];
            rsp_ready = (i == bp);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        pcpi_ready = 1'b0;
        @(negedge clk);
        check_eq("rsp_drop", r_val[s], 0);
        check_eq("req_ready_after", rq_rdy[s], 1);
        check_eq("pcpi_insn_retained", p_insn[s], insn);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        seen;
        logic [31:0] ins;

        #12;
        check_eq("rst_req_ready", {rq_rdy[0], rq_rdy[1]}, 0);
        check_eq("rst_pcpi", {p_val[0], p_insn[0], p_rs1[0], p_rs2[0]}, 0);
        check_eq("rst_rsp", {r_val[0], r_wr[0], r_ill[0], r_addr[0], r_rd[0]}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("req_ready_post_rst", {rq_rdy[0], rq_rdy[1]}, 2'b11);

        // Fast multiplier answering on its second cycle of pcpi_valid.
        run_txn(0, 32'h02B50533, 32'd7, 32'hFFFFFFFD, 1, 0, 1,
                mul_ref(32'h02B50533, 32'd7, 32'hFFFFFFFD), 0, got);
        check_eq("mul_const", got, 32'hFFFFFFEB);
        run_txn(0, 32'h02B53533, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1,
                mul_ref(32'h02B53533, 32'hFFFFFFFF, 32'hFFFFFFFF), 0, got);
        check_eq("mulhu_const", got, 32'hFFFFFFFE);
        run_txn(0, 32'h02B51533, 32'h80000000, 32'd2, 1, 0, 1,
                mul_ref(32'h02B51533, 32'h80000000, 32'd2), 0, got);
        check_eq("mulh_const", got, 32'hFFFFFFFF);

        run_txn(0, 32'h00B50533, 32'd1, 32'd2, -1, 0, 0, 32'd0, 2, got);
        run_txn(0, 32'h02B50533, 32'd3, 32'd4, 30, 30, 1, 32'h12345678, 1, got);
        check_eq("wait_ext_rd", got, 32'h12345678);
        run_txn(1, 32'h02B50533, 32'd3, 32'd4, 30, 30, 1, 32'h12345678, 1, got);
        check_eq("wait_ign_rd", got, 32'd0);
        run_txn(0, 32'h02B50533, 32'd5, 32'd6, T - 1, 0, 1, 32'hCAFEF00D, 5, got);
        check_eq("ready_beats_timeout", got, 32'hCAFEF00D);
        run_txn(1, 32'h02B50733, 32'd5, 32'd6, 0, 0, 0, 32'hDEADBEEF, 5, got);

        // Asynchronous reset in the 5th cycle of a timeout run.
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_insn = 32'h00B50533;
        req_rs1 = 32'h11;
        req_rs2 = 32'h22;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_pcpi", {p_val[0], p_insn[0], p_rs1[0], p_rs2[0]}, 0);
        check_eq("arst_rsp", {r_val[0], rq_rdy[0]}, 0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            pcpi_ready = 1'($urandom);
            rsp_ready = 1'($urandom);
            @(negedge clk);
            seen = seen | r_val[0] | p_val[0];
        end
        pcpi_ready = 1'b0;
        rsp_ready = 1'b0;
        check_eq("no_rsp_after_rst", seen, 0);
        run_txn(0, 32'h02B50533, 32'd9, 32'd9, 1, 0, 1, mul_ref(32'h02B50533, 32'd9, 32'd9), 0, got);
        check_eq("mul_after_rst", got, 32'd81);

        for (int n = 0; n < 30; n++) begin
            int r, w;
            logic s, wr;
            s = 1'($urandom);
            r = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 24));
            w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : 0;
            wr = 1'($urandom);
            ins = $urandom;
            run_txn(s, ins, $urandom, $urandom, r, w, wr, $urandom, int'($urandom_range(0, 5)), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
